spi_slave: RTL and testbench

- SPI peripheral-side endpoint: the far end of the link driven by our SPI master.
- Samples SCLK/CS/MOSI, oversampled by the system clock. Fixed mode 0 (CPOL=0, CPHA=0), MSB first.
- Deserialises MOSI into rx_data and serialises a buffered tx word onto MISO.
- Sits between the SPI pins and a local register/FIFO client using a valid/ready tx interface and a pulsed rx interface.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave.sv | 165 ++++++++++++++++
 tb/tb_spi_slave.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width, idle tx pattern, synchroniser depth and FSM encoding.
// The master side reuses SPI_WIDTH from here.
package spi_pkg;

  localparam int SPI_WIDTH       = 8;
  localparam int SPI_SYNC_STAGES = 2;
  localparam logic [SPI_WIDTH-1:0] SPI_DEFAULT_TX = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for one asynchronous pin, with rise/fall pulses taken from
// the synchronised level against a one-cycle-delayed copy.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES    = SPI_SYNC_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= {STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 peripheral endpoint, MSB first, oversampled by clk_i.
// State | meaning: ST_IDLE | CS high, MISO low, SCLK ignored; ST_ACTIVE | CS low, shifting words.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                WIDTH       = SPI_WIDTH,
  parameter int                SYNC_STAGES = SPI_SYNC_STAGES,
  parameter logic [WIDTH-1:0]  DEFAULT_TX  = SPI_DEFAULT_TX
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             sclk_i,
  input  logic             cs_i,
  input  logic             mosi_i,
  output logic             miso_o,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             tx_underrun_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic sclk_rise, sclk_fall, sclk_unused;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             underrun_q, underrun_d;
  logic             load, accept;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (sclk_i),
    .q_o     (sclk_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  // CS resets high so leaving reset never looks like a frame start.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (cs_i),
    .q_o     (cs_s),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign accept = tx_valid_i & ~buf_full_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    underrun_d  = 1'b0;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = '0;
          load      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = '0;
          frame_err_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[WIDTH-3:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          // A fall with bit_cnt at zero follows a completed word: start the next one.
          if (bit_cnt_q == '0) load = 1'b1;
          else                 tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_shift_d = DEFAULT_TX;
        underrun_d = 1'b1;
      end
    end

    // accept needs an empty buffer, so it never collides with a consuming load.
    if (accept) begin
      buf_d      = tx_data_i;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mosi_sync_q <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      underrun_q  <= underrun_d;
    end
  end

  assign miso_o        = (state_q == ST_ACTIVE) & tx_shift_q[WIDTH-1];
  assign tx_ready_o    = ~buf_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign busy_o        = ~cs_s;
  assign frame_err_o   = frame_err_q;
  assign tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-level SPI master drives frames, expected rx words go to a
// scoreboard queue checked by a monitor, and a tx-buffer model predicts each MISO word.
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk_i = 1'b0;
  logic       reset_i, sclk_i, cs_i, mosi_i, tx_valid_i;
  logic [7:0] tx_data_i;
  logic       miso_o, tx_ready_o, rx_valid_o, busy_o, frame_err_o, tx_underrun_o;
  logic [7:0] rx_data_o;

  spi_slave dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .sclk_i        (sclk_i),
    .cs_i          (cs_i),
    .mosi_i        (mosi_i),
    .miso_o        (miso_o),
    .tx_data_i     (tx_data_i),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_o    (tx_ready_o),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .busy_o        (busy_o),
    .frame_err_o   (frame_err_o),
    .tx_underrun_o (tx_underrun_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_model[$];
  int exp_und = 0, exp_err = 0, n_und = 0, n_err = 0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] mon_e;

  // Scoreboard monitor: every rx_valid pulse must match the oldest word the master sent.
  always @(negedge clk_i) begin
    if (rx_valid_o) begin
      total++;
      if (exp_rx.size() == 0) begin
        bad++;
        $display("FAIL rx_unexpected got=%h exp=none", rx_data_o);
      end else begin
        mon_e = exp_rx.pop_front();
        if (rx_data_o !== mon_e) begin
          bad++;
          $display("FAIL rx_word got=%h exp=%h", rx_data_o, mon_e);
        end
      end
    end
    if (frame_err_o)   n_err++;
    if (tx_underrun_o) n_und++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Buffer model: a word loaded into the shifter is the buffered one, else the idle pattern.
  function automatic logic [7:0] load_word();
    if (tx_model.size() > 0) return tx_model.pop_front();
    exp_und++;
    return SPI_DEFAULT_TX;
  endfunction

  task automatic tx_push(input logic [7:0] d);
    int w = 0;
    while (!tx_ready_o && w < 300) begin
      tick(1);
      w++;
    end
    check("tx_push_ready", tx_ready_o, 1);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    tick(1);
    tx_valid_i = 1'b0;
    tx_model.push_back(d);
  endtask

  task automatic send_bits(input logic [7:0] w, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi_i = w[7-i];
      sclk_i = 1'b0;
      tick(4);
      got = {got[6:0], miso_o};
      sclk_i = 1'b1;
      tick(4);
    end
  endtask

  // CS is raised while SCLK is still high, so the trailing fall lands in IDLE.
  task automatic end_frame();
    cs_i = 1'b1;
    tick(4);
    sclk_i = 1'b0;
    tick(4);
  endtask

  task automatic frame(input int nw, input logic [7:0] w0, input logic [7:0] w1);
    logic [7:0] exp_m, got, w;
    cs_i = 1'b0;
    tick(2);
    for (int k = 0; k < nw; k++) begin
      exp_m = load_word();
      w = (k == 0) ? w0 : w1;
      exp_rx.push_back(w);
      last_rx = w;
      send_bits(w, 8, got);
      check("miso_word", got, exp_m);
    end
    end_frame();
    check("rx_drained", exp_rx.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},      miso_o, 0);
    check({tag, "_tx_ready"},  tx_ready_o, 1);
    check({tag, "_rx_data"},   rx_data_o, 0);
    check({tag, "_rx_valid"},  rx_valid_o, 0);
    check({tag, "_busy"},      busy_o, 0);
    check({tag, "_frame_err"}, frame_err_o, 0);
    check({tag, "_underrun"},  tx_underrun_o, 0);
  endtask

  initial begin
    int u0, e0, w;
    logic [7:0] r0, r1, got;

    reset_i = 1'b1; cs_i = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0;
    tx_valid_i = 1'b0; tx_data_i = 8'h00;
    tick(3);
    check_reset_outputs("reset");
    reset_i = 1'b0;
    tick(2);

    // Basic exchange
    tx_push(8'h5C);
    check("basic_ready_low", tx_ready_o, 0);
    u0 = n_und;
    frame(1, 8'hB3, 8'h00);
    check("basic_ready_back", tx_ready_o, 1);
    check("basic_rx_data", rx_data_o, 8'hB3);
    check("basic_no_underrun", n_und - u0, 0);

    // Back-to-back words in one frame, second tx word loaded mid-frame
    tx_push(8'hA5);
    u0 = n_und;
    fork
      frame(2, 8'h11, 8'hEE);
      tx_push(8'h3C);
    join
    check("b2b_no_underrun", n_und - u0, 0);

    // Underrun
    u0 = n_und;
    frame(1, 8'h00, 8'h00);
    check("underrun_pulse", n_und - u0, 1);
    check("underrun_rx_data", rx_data_o, 8'h00);

    // Randomised frames with optional tx preload
    repeat (8) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      if ($urandom_range(0, 1) == 1) tx_push(8'($urandom));
      frame(int'($urandom_range(1, 2)), r0, r1);
    end

    // Mid-word abort after four rises
    e0 = n_err;
    cs_i = 1'b0;
    tick(2);
    void'(load_word());
    r0 = 8'($urandom);
    send_bits(r0, 4, got);
    end_frame();
    exp_err++;
    check("abort_frame_err", n_err - e0, 1);
    check("abort_rx_held", rx_data_o, last_rx);
    frame(1, 8'h81, 8'h00);

    // Reset in the middle of a frame
    e0 = n_err;
    cs_i = 1'b0;
    tick(2);
    void'(load_word());
    send_bits(8'h5A, 5, got);
    reset_i = 1'b1; cs_i = 1'b1; sclk_i = 1'b0;
    tick(1);
    check_reset_outputs("midreset");
    tick(2);
    reset_i = 1'b0;
    tx_model.delete();
    last_rx = 8'h00;
    tick(6);
    check("midreset_no_frame_err", n_err - e0, 0);
    frame(1, 8'hC3, 8'h00);

    // Backpressure: 8'h77 held on tx_valid while the buffer holds 8'h44
    tx_push(8'h44);
    tx_data_i  = 8'h77;
    tx_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("bp_ready_low", tx_ready_o, 0);
    end
    r0 = 8'($urandom);
    r1 = 8'($urandom);
    fork
      frame(2, r0, r1);
      begin
        w = 0;
        while (!tx_ready_o && w < 300) begin
          tick(1);
          w++;
        end
        check("bp_ready_returns", tx_ready_o, 1);
        tick(1);
        tx_valid_i = 1'b0;
        tx_model.push_back(8'h77);
        check("bp_accepted", tx_ready_o, 0);
      end
    join

    tick(4);
    check("final_underrun_count", n_und, exp_und);
    check("final_frame_err_count", n_err, exp_err);
    check("final_rx_queue_empty", exp_rx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
